// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: FSM encoding, parity modes
// and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_DONE     = 3'd5,
    ST_BRK_WAIT = 3'd6
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial-line synchroniser and 3-sample majority voter around the bit centre.
// The third vote is taken live, so bit_val is valid in the bit_strobe cycle.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CNT_W = 7,
  parameter int HALF  = 43
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_serial,
  input  logic [CNT_W-1:0] cnt,
  output logic             rx_s,
  output logic             bit_val,
  output logic             bit_strobe
);

  localparam logic [CNT_W-1:0] CNT_A = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_B = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_C = CNT_W'(HALF + 1);

  logic rx_p0;
  logic rx_p1;
  logic smp_a;
  logic smp_b;

  // stage p0/p1: two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_serial;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (cnt == CNT_A) smp_a <= rx_p1;
    if (cnt == CNT_B) smp_b <= rx_p1;
  end

  assign rx_s       = rx_p1;
  assign bit_strobe = (cnt == CNT_C);
  assign bit_val    = maj3(smp_a, smp_b, rx_p1);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: configurable data bits, parity and stop bits,
// with parity/framing/break flags and a valid/ready output register.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_Rx_serial,
  input  logic                 i_Rx_ready,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD_FLIP  = (PARITY == PAR_ODD);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic                 ferr_acc, ferr_acc_nxt;
  logic                 brk_hold;
  logic                 rx_s;
  logic                 bit_val;
  logic                 bit_strobe;
  logic                 wrap;
  logic                 shift_en;
  logic                 par_cap;
  logic                 done_load;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 fin_ferr;
  logic                 fin_perr;
  logic                 fin_brk;

  uart_rx_sampler #(
    .CNT_W (CNT_W),
    .HALF  (HALF)
  ) u_sampler (
    .clk        (i_clock),
    .rst        (i_reset),
    .rx_serial  (i_Rx_serial),
    .cnt        (cnt),
    .rx_s       (rx_s),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe)
  );

  assign wrap = (cnt == CNT_LAST);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = wrap ? '0 : cnt + CNT_W'(1);
    idx_nxt      = idx;
    stop_idx_nxt = stop_idx;
    ferr_acc_nxt = ferr_acc;
    shift_en     = 1'b0;
    par_cap      = 1'b0;
    done_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt      = '0;
        idx_nxt      = '0;
        stop_idx_nxt = 1'b0;
        ferr_acc_nxt = 1'b0;
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (bit_strobe && bit_val) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (wrap) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        shift_en = bit_strobe;
        if (wrap) begin
          if (idx == IDX_LAST) state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      ST_PARITY: begin
        par_cap = bit_strobe;
        if (wrap) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_strobe && !bit_val) ferr_acc_nxt = 1'b1;
        // Leave on the final decision rather than the wrap so a fast sender is never missed.
        if (bit_strobe && (stop_idx == STOP_LAST)) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
          done_load = 1'b1;
        end else if (wrap) begin
          stop_idx_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        cnt_nxt   = '0;
        state_nxt = brk_hold ? ST_BRK_WAIT : ST_IDLE;
      end
      ST_BRK_WAIT: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      ferr_acc <= 1'b0;
      brk_hold <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      stop_idx <= stop_idx_nxt;
      ferr_acc <= ferr_acc_nxt;
      if (done_load) brk_hold <= fin_brk;
    end
  end

  always_ff @(posedge i_clock) begin
    if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
    if (par_cap)  par_bit <= bit_val;
  end

  // Frame verdict including the stop decision being made this cycle.
  assign fin_ferr = ferr_acc | ~bit_val;
  assign fin_perr = (PARITY != PAR_NONE) && (par_bit != ((^shreg) ^ ODD_FLIP));
  assign fin_brk  = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && fin_ferr;

  // stage p0: output register, loaded in the cycle the frame completes
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_Rx_DV      <= 1'b0;
      o_Rx_byte    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done_load) begin
        if (!o_Rx_DV || i_Rx_ready) begin
          o_Rx_DV      <= 1'b1;
          o_Rx_byte    <= shreg;
          o_parity_err <= fin_perr;
          o_frame_err  <= fin_ferr;
          o_break      <= fin_brk;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_Rx_DV && i_Rx_ready) begin
        o_Rx_DV <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: 8N1, 8E1 and 5N2 receivers on separate lines.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  localparam int CLKS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic [2:0] rx = 3'b111;

  logic       dv_a, pe_a, fe_a, bk_a, ov_a;
  logic [7:0] rb_a;
  logic       dv_b, pe_b, fe_b, bk_b, ov_b;
  logic [7:0] rb_b;
  logic       dv_c, pe_c, fe_c, bk_c, ov_c;
  logic [4:0] rb_c;

  int n_vec = 0;
  int n_err = 0;

  int         nf_a = 0;
  int         no_a = 0;
  logic [7:0] lb_a = '0;
  logic [2:0] lfl_a = '0;

  always #5 clk = ~clk;

  uart_rx_ext #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_clock(clk), .i_reset(rst), .i_Rx_serial(rx[0]), .i_Rx_ready(ready),
    .o_Rx_DV(dv_a), .o_Rx_byte(rb_a), .o_parity_err(pe_a), .o_frame_err(fe_a),
    .o_break(bk_a), .o_overrun(ov_a));

  uart_rx_ext #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .i_clock(clk), .i_reset(rst), .i_Rx_serial(rx[1]), .i_Rx_ready(ready),
    .o_Rx_DV(dv_b), .o_Rx_byte(rb_b), .o_parity_err(pe_b), .o_frame_err(fe_b),
    .o_break(bk_b), .o_overrun(ov_b));

  uart_rx_ext #(.CLKS_PER_BIT(CLKS), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_c (
    .i_clock(clk), .i_reset(rst), .i_Rx_serial(rx[2]), .i_Rx_ready(ready),
    .o_Rx_DV(dv_c), .o_Rx_byte(rb_c), .o_parity_err(pe_c), .o_frame_err(fe_c),
    .o_break(bk_c), .o_overrun(ov_c));

  // Records every cycle receiver A presents a frame, so one-cycle valids are not missed.
  always @(negedge clk) begin
    if (dv_a) begin
      nf_a  <= nf_a + 1;
      lb_a  <= rb_a;
      lfl_a <= {pe_a, fe_a, bk_a};
    end
    if (ov_a) no_a <= no_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bits(input int sel, input logic [15:0] seq, input int len, input bit spike);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < CLKS; c++) begin
        @(negedge clk);
        rx[sel] = (spike && i >= 1 && i <= len - 2 && c == CLKS / 2) ? ~seq[i] : seq[i];
      end
    end
    @(negedge clk);
    rx[sel] = 1'b1;
  endtask

  task automatic send(input int sel, input logic [8:0] d, input int nb, input bit has_par,
                      input logic pbit, input logic [1:0] stops, input int ns, input bit spike);
    logic [15:0] seq;
    int n;
    seq = '1;
    n = 0;
    seq[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin seq[n] = d[i]; n++; end
    if (has_par) begin seq[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin seq[n] = stops[i]; n++; end
    drive_bits(sel, seq, n, spike);
  endtask

  task automatic accept();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int base_o;
    logic [15:0] part;

    idle(3);
    chk("reset_ctl", {dv_a, pe_a, fe_a, bk_a, ov_a}, 5'b00000);
    chk("reset_byte", rb_a, 8'h00);
    rst = 1'b0;
    idle(20);

    // 8N1 0xA5 with ready held high
    ready = 1'b1;
    base = nf_a;
    send(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 0);
    idle(4);
    chk("a5_dv_cycles", nf_a - base, 1);
    chk("a5_byte", lb_a, 8'hA5);
    chk("a5_flags", lfl_a, 3'b000);
    chk("a5_dv_clear", dv_a, 1'b0);

    // stop bit low
    base = nf_a;
    send(0, 9'h05A, 8, 0, 1'b0, 2'b10, 1, 0);
    idle(3 * CLKS);
    chk("ferr_frames", nf_a - base, 1);
    chk("ferr_byte", lb_a, 8'h5A);
    chk("ferr_flags", lfl_a, 3'b010);

    // line low for 12 bit-times
    base = nf_a;
    @(negedge clk);
    rx[0] = 1'b0;
    idle(12 * CLKS);
    rx[0] = 1'b1;
    idle(12 * CLKS);
    chk("brk_frames", nf_a - base, 1);
    chk("brk_byte", lb_a, 8'h00);
    chk("brk_flags", lfl_a, 3'b011);

    // short low glitch on an idle line
    base = nf_a;
    @(negedge clk);
    rx[0] = 1'b0;
    idle(4);
    rx[0] = 1'b1;
    idle(3 * CLKS);
    chk("glitch_frames", nf_a - base, 0);

    // one-cycle spikes inside each data bit
    base = nf_a;
    send(0, 9'h0C3, 8, 0, 1'b0, 2'b11, 1, 1);
    idle(4);
    chk("spike_frames", nf_a - base, 1);
    chk("spike_byte", lb_a, 8'hC3);
    chk("spike_flags", lfl_a, 3'b000);

    // overrun: two frames without accept
    ready = 1'b0;
    base_o = no_a;
    send(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, 0);
    idle(CLKS);
    send(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, 0);
    idle(4);
    chk("ovr_dv", dv_a, 1'b1);
    chk("ovr_byte", rb_a, 8'h11);
    chk("ovr_pulses", no_a - base_o, 1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    chk("ovr_accept_dv", dv_a, 1'b0);
    ready = 1'b0;

    // reset in the middle of data bit 4, with a frame held in the output register
    send(0, 9'h07E, 8, 0, 1'b0, 2'b11, 1, 0);
    idle(4);
    chk("pre_rst_dv", dv_a, 1'b1);
    part = '1;
    part[0] = 1'b0;
    part[4:1] = 4'hC;
    drive_bits(0, part, 5, 0);
    idle(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctl", {dv_a, pe_a, fe_a, bk_a, ov_a}, 5'b00000);
    chk("midrst_byte", rb_a, 8'h00);
    idle(2 * CLKS);
    ready = 1'b1;
    base = nf_a;
    send(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, 0);
    idle(4);
    chk("post_rst_frames", nf_a - base, 1);
    chk("post_rst_byte", lb_a, 8'h3C);
    chk("post_rst_flags", lfl_a, 3'b000);
    ready = 1'b0;

    // even parity, 0x07 has odd weight so the correct parity bit is 1
    send(1, 9'h007, 8, 1, 1'b0, 2'b11, 1, 0);
    idle(4);
    chk("par0_dv", dv_b, 1'b1);
    chk("par0_byte", rb_b, 8'h07);
    chk("par0_flags", {pe_b, fe_b, bk_b}, 3'b100);
    accept();
    chk("par0_accept", dv_b, 1'b0);
    send(1, 9'h007, 8, 1, 1'b1, 2'b11, 1, 0);
    idle(4);
    chk("par1_byte", rb_b, 8'h07);
    chk("par1_flags", {pe_b, fe_b, bk_b}, 3'b000);
    accept();

    // 5 data bits, 2 stop bits
    send(2, 9'h015, 5, 0, 1'b0, 2'b11, 2, 0);
    idle(4);
    chk("d5_dv", dv_c, 1'b1);
    chk("d5_byte", rb_c, 5'h15);
    chk("d5_flags", {pe_c, fe_c, bk_c}, 3'b000);
    accept();
    send(2, 9'h015, 5, 0, 1'b0, 2'b01, 2, 0);
    idle(4);
    chk("d5_stop2_byte", rb_c, 5'h15);
    chk("d5_stop2_flags", {pe_c, fe_c, bk_c}, 3'b010);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
